// File: rtl/enable_chk_debounce.sv
// Synchronised, debounced key/switch bus with a press strobe, captured code,
// lowest-set index and multi-key flag. Optional press counter: ENABLE_CHK_PRESS_CNT_EN.
module enable_chk_debounce #(
  parameter int WIDTH    = 8,
  parameter int IDX_W    = 3,
  parameter int DEBOUNCE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_bus,
  output logic             en_level,
  output logic             press_pulse,
  output logic [WIDTH-1:0] press_code,
  output logic [IDX_W-1:0] press_idx,
  output logic             multi,
`ifdef ENABLE_CHK_PRESS_CNT_EN
  output logic [7:0]       press_count,
`endif
  output logic             busy
);

  // state       | meaning
  // ST_IDLE     | no key seen, waiting for a nonzero bus
  // ST_DEBOUNCE | counting identical nonzero samples toward a press
  // ST_HELD     | press accepted, waiting for the bus to go to zero
  // ST_RELEASE  | counting zero samples toward a release
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DEBOUNCE,
    ST_HELD,
    ST_RELEASE
  } state_t;

  localparam logic [7:0] DB_CNT = 8'(DEBOUNCE);

  state_t           state;
  logic [WIDTH-1:0] sync_q1;
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] sample;
  logic [7:0]       cnt;
  logic [7:0]       cnt_inc;
  logic             s_nz;
  logic             accept_now;
  logic [WIDTH-1:0] accept_val;

  function automatic logic [IDX_W-1:0] lowest_idx(input logic [WIDTH-1:0] v);
    lowest_idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (v[i]) lowest_idx = IDX_W'(i);
    end
  endfunction

  // Clearing the lowest set bit leaves something only if two or more were set.
  function automatic logic more_than_one(input logic [WIDTH-1:0] v);
    more_than_one = (v & (v - WIDTH'(1))) != '0;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q1  <= '0;
      s        <= '0;
      en_level <= 1'b0;
    end else begin
      sync_q1  <= in_bus;
      s        <= sync_q1;
      en_level <= |s;
    end
  end

  assign s_nz    = s != '0;
  assign cnt_inc = cnt + 8'd1;

  // With a single-sample debounce the IDLE state accepts the live bus directly.
  always_comb begin
    accept_now = 1'b0;
    accept_val = sample;
    if (state == ST_IDLE) begin
      accept_val = s;
      accept_now = s_nz && (DEBOUNCE == 1);
    end else if (state == ST_DEBOUNCE) begin
      accept_now = s_nz && (s == sample) && (cnt_inc == DB_CNT);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      sample      <= '0;
      cnt         <= '0;
      busy        <= 1'b0;
      press_pulse <= 1'b0;
      press_code  <= '0;
      press_idx   <= '0;
      multi       <= 1'b0;
    end else begin
      press_pulse <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (s_nz) begin
            sample <= s;
            cnt    <= 8'd1;
            busy   <= 1'b1;
            state  <= (DEBOUNCE == 1) ? ST_HELD : ST_DEBOUNCE;
          end
        end
        ST_DEBOUNCE: begin
          if (!s_nz) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else if (s != sample) begin
            sample <= s;
            cnt    <= 8'd1;
          end else begin
            cnt <= cnt_inc;
            if (cnt_inc == DB_CNT) state <= ST_HELD;
          end
        end
        ST_HELD: begin
          if (!s_nz) begin
            cnt <= 8'd1;
            if (DEBOUNCE == 1) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end else begin
              state <= ST_RELEASE;
            end
          end
        end
        ST_RELEASE: begin
          if (s_nz) begin
            state <= ST_HELD;
          end else begin
            cnt <= cnt_inc;
            if (cnt_inc == DB_CNT) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase

      if (accept_now) begin
        press_pulse <= 1'b1;
        press_code  <= accept_val;
        press_idx   <= lowest_idx(accept_val);
        multi       <= more_than_one(accept_val);
      end
    end
  end

`ifdef ENABLE_CHK_PRESS_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      press_count <= '0;
    end else if (accept_now && press_count != 8'hFF) begin
      press_count <= press_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_enable_chk_debounce.sv
// Bench for enable_chk_debounce: directed scenarios plus random bursts, all
// checked each cycle against a run-length reference model.
module tb_enable_chk_debounce;
  localparam int WIDTH = 8;
  localparam int IDX_W = 3;
  localparam int DB    = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] in_bus;
  logic             en_level;
  logic             press_pulse;
  logic [WIDTH-1:0] press_code;
  logic [IDX_W-1:0] press_idx;
  logic             multi;
  logic             busy;
`ifdef ENABLE_CHK_PRESS_CNT_EN
  logic [7:0]       press_count;
`endif

  enable_chk_debounce #(.WIDTH(WIDTH), .IDX_W(IDX_W), .DEBOUNCE(DB)) dut (
    .clk(clk),
    .rst(rst),
    .in_bus(in_bus),
    .en_level(en_level),
    .press_pulse(press_pulse),
    .press_code(press_code),
    .press_idx(press_idx),
    .multi(multi),
`ifdef ENABLE_CHK_PRESS_CNT_EN
    .press_count(press_count),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: two-sample delay line, then a run-length rule.
  // Unpressed: DB consecutive identical nonzero samples make a press.
  // Pressed: DB consecutive zero samples make a release.
  logic [WIDTH-1:0] m_s1, m_s2, m_run_val;
  int               m_run;
  bit               m_pressed;
  logic             e_en, e_pulse, e_multi, e_busy;
  logic [WIDTH-1:0] e_code;
  logic [IDX_W-1:0] e_idx;
  int               e_count;

  int edge_n, pulse_n, first_en_edge, last_pulse_edge;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_s1 = '0; m_s2 = '0; m_run_val = '0; m_run = 0; m_pressed = 0;
    e_en = 0; e_pulse = 0; e_multi = 0; e_busy = 0; e_code = '0; e_idx = '0;
    e_count = 0;
  endfunction

  function automatic void model_edge(input logic [WIDTH-1:0] r);
    logic [WIDTH-1:0] sv;
    sv = m_s2;
    e_pulse = 0;
    e_en = |sv;
    if (!m_pressed) begin
      if (sv != '0) begin
        if (m_run > 0 && sv == m_run_val) m_run++;
        else begin
          m_run_val = sv;
          m_run = 1;
        end
        if (m_run == DB) begin
          e_pulse = 1;
          e_code = sv;
          for (int i = 0; i < WIDTH; i++) begin
            if (sv[i]) begin
              e_idx = IDX_W'(i);
              break;
            end
          end
          e_multi = $countones(sv) > 1;
          if (e_count < 255) e_count++;
          m_pressed = 1;
          m_run = 0;
        end
      end else begin
        m_run = 0;
      end
    end else begin
      if (sv == '0) begin
        m_run++;
        if (m_run == DB) begin
          m_pressed = 0;
          m_run = 0;
        end
      end else begin
        m_run = 0;
      end
    end
    e_busy = m_pressed || (m_run > 0);
    m_s2 = m_s1;
    m_s1 = r;
  endfunction

  task automatic check_outputs();
    check("en_level", 32'(en_level), 32'(e_en));
    check("press_pulse", 32'(press_pulse), 32'(e_pulse));
    check("press_code", 32'(press_code), 32'(e_code));
    check("press_idx", 32'(press_idx), 32'(e_idx));
    check("multi", 32'(multi), 32'(e_multi));
    check("busy", 32'(busy), 32'(e_busy));
`ifdef ENABLE_CHK_PRESS_CNT_EN
    check("press_count", 32'(press_count), 32'(e_count));
`endif
  endtask

  task automatic mark();
    edge_n = 0; pulse_n = 0; first_en_edge = 0; last_pulse_edge = 0;
  endtask

  task automatic step(input logic [WIDTH-1:0] r);
    in_bus = r;
    @(posedge clk);
    model_edge(r);
    #1;
    edge_n++;
    if (press_pulse) begin
      pulse_n++;
      last_pulse_edge = edge_n;
    end
    if (en_level && first_en_edge == 0) first_en_edge = edge_n;
    check_outputs();
  endtask

  task automatic steps(input logic [WIDTH-1:0] r, input int n);
    for (int k = 0; k < n; k++) step(r);
  endtask

  task automatic do_reset(input logic [WIDTH-1:0] r);
    in_bus = r;
    rst = 1'b1;
    #2;
    model_reset();
    check("rst_en_level", 32'(en_level), 32'd0);
    check("rst_pulse", 32'(press_pulse), 32'd0);
    check("rst_code", 32'(press_code), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check_outputs();
    #2;
    rst = 1'b0;
  endtask

  logic [WIDTH-1:0] rv, prev_rv;

  initial begin
    model_reset();
    mark();
    do_reset(8'hFF);

    // idle bus after reset
    mark();
    steps(8'h00, 20);
    check("idle_pulses", 32'(pulse_n), 32'd0);

    // clean press
    mark();
    steps(8'h10, 10);
    check("clean_en_edge", 32'(first_en_edge), 32'd3);
    check("clean_pulse_edge", 32'(last_pulse_edge), 32'(DB + 2));
    check("clean_pulses", 32'(pulse_n), 32'd1);
    check("clean_code", 32'(press_code), 32'h10);
    check("clean_idx", 32'(press_idx), 32'd4);
    check("clean_multi", 32'(multi), 32'd0);
    steps(8'h00, 8);

    // press bounce
    mark();
    steps(8'h04, 2);
    steps(8'h00, 1);
    steps(8'h04, 8);
    check("bounce_pulses", 32'(pulse_n), 32'd1);
    check("bounce_pulse_edge", 32'(last_pulse_edge), 32'(4 + DB + 1));
    check("bounce_code", 32'(press_code), 32'h04);
    check("bounce_idx", 32'(press_idx), 32'd2);
    steps(8'h00, 8);

    // multi-key then change while held
    mark();
    steps(8'h82, 8);
    check("multi_pulses", 32'(pulse_n), 32'd1);
    check("multi_code", 32'(press_code), 32'h82);
    check("multi_idx", 32'(press_idx), 32'd1);
    check("multi_flag", 32'(multi), 32'd1);
    mark();
    steps(8'h80, 8);
    check("held_change_pulses", 32'(pulse_n), 32'd0);
    check("held_code", 32'(press_code), 32'h82);

    // release bounce
    mark();
    steps(8'h00, 2);
    steps(8'h82, 1);
    steps(8'h00, 4);
    steps(8'h00, 2);
    check("rel_bounce_pulses", 32'(pulse_n), 32'd0);
    check("rel_busy_low", 32'(busy), 32'd0);
    steps(8'h01, 8);
    check("fresh_pulses", 32'(pulse_n), 32'd1);
    check("fresh_code", 32'(press_code), 32'h01);
    steps(8'h00, 8);

    // reset mid-debounce (cnt==2 after the 4th edge)
    mark();
    steps(8'h10, 4);
    do_reset(8'h10);
    check("midrst_pulses", 32'(pulse_n), 32'd0);
    steps(8'h10, 8);
    steps(8'h00, 8);

    // random bursts with occasional asynchronous reset
    prev_rv = '0;
    for (int seg = 0; seg < 400; seg++) begin
      case ($urandom_range(0, 3))
        0: rv = '0;
        1: rv = WIDTH'(1) << $urandom_range(0, WIDTH - 1);
        2: rv = WIDTH'($urandom_range(1, 255));
        default: rv = prev_rv;
      endcase
      steps(rv, $urandom_range(1, 7));
      prev_rv = rv;
      if ($urandom_range(0, 39) == 0) do_reset(WIDTH'($urandom));
    end

`ifdef ENABLE_CHK_PRESS_CNT_EN
    do_reset(8'h00);
    for (int p = 0; p < 300; p++) begin
      steps(8'h01, 8);
      steps(8'h00, 8);
    end
    check("count_saturated", 32'(press_count), 32'd255);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not finish, got running expected done");
    $fatal(1, "timeout");
  end
endmodule
